// File: rtl/move_list_streamer.sv
// Move-list streamer: walks the move RAM written by the move generator, optionally
// keeps only captures, emits one record per move over a valid/ready handshake, then
// emits a trailer carrying game status and the emitted-record count, and finally
// releases the move generator with a one-cycle clear pulse.
module move_list_streamer #(
  parameter int unsigned MAX_POSITIONS_LOG2 = 8,
  parameter int unsigned EVAL_WIDTH         = 24,
  parameter int unsigned UCI_WIDTH          = 16,
  parameter int unsigned RAM_LATENCY        = 2,
  parameter int unsigned CLEAR_WAIT         = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                capture_only,
  // Move-generator status
  input  logic                                am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0]       am_move_count,
  input  logic                                initial_mate,
  input  logic                                initial_stalemate,
  input  logic                                initial_thrice_rep,
  // Move-RAM read data
  input  logic [UCI_WIDTH-1:0]                uci_in,
  input  logic signed [EVAL_WIDTH-1:0]        eval_in,
  input  logic                                capture_in,
  input  logic                                white_in_check_in,
  input  logic                                black_in_check_in,
  output logic [MAX_POSITIONS_LOG2-1:0]       am_move_index,
  output logic                                am_clear_moves,
  // Record stream
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [UCI_WIDTH-1:0]                out_uci,
  output logic signed [EVAL_WIDTH-1:0]        out_eval,
  output logic                                out_capture,
  output logic [1:0]                          out_check,
  output logic [MAX_POSITIONS_LOG2-1:0]       out_index,
  output logic                                out_trailer,
  output logic [2:0]                          out_status,
  output logic [MAX_POSITIONS_LOG2:0]         out_emitted,
  output logic                                busy
);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StWait,
    StSample,
    StEmit,
    StTrailer,
    StClear,
    StClearWait
  } state_e;

  localparam logic [3:0]                  RamWaitInit   = 4'(RAM_LATENCY - 1);
  localparam logic [3:0]                  ClearWaitInit = 4'(CLEAR_WAIT);
  localparam logic [MAX_POSITIONS_LOG2:0] WideOne       = (MAX_POSITIONS_LOG2 + 1)'(1);

  state_e                        state_q;
  logic [MAX_POSITIONS_LOG2-1:0] idx_q;
  logic [MAX_POSITIONS_LOG2-1:0] count_q;
  logic                          cap_only_q;
  logic [3:0]                    wait_q;

  logic [MAX_POSITIONS_LOG2:0]   idx_inc;
  logic                          more_moves;

  // Next-index arithmetic one bit wider than the index so the last entry never wraps.
  always_comb begin
    idx_inc    = {1'b0, idx_q} + WideOne;
    more_moves = idx_inc < {1'b0, count_q};
  end

  // Streamer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      count_q        <= '0;
      cap_only_q     <= 1'b0;
      wait_q         <= '0;
      am_move_index  <= '0;
      am_clear_moves <= 1'b0;
      out_valid      <= 1'b0;
      out_uci        <= '0;
      out_eval       <= '0;
      out_capture    <= 1'b0;
      out_check      <= '0;
      out_index      <= '0;
      out_trailer    <= 1'b0;
      out_status     <= '0;
      out_emitted    <= '0;
      busy           <= 1'b0;
    end else begin
      am_clear_moves <= 1'b0;
      unique case (state_q)
        StIdle: begin
          am_move_index <= '0;
          if (enable && am_moves_ready) begin
            count_q     <= am_move_count;
            out_status  <= {initial_thrice_rep, initial_stalemate, initial_mate};
            cap_only_q  <= capture_only;
            out_emitted <= '0;
            busy        <= 1'b1;
            state_q     <= StStart;
          end
        end

        StStart: begin
          if (count_q == '0) begin
            out_valid   <= 1'b1;
            out_trailer <= 1'b1;
            out_uci     <= '0;
            out_eval    <= '0;
            out_capture <= 1'b0;
            out_check   <= '0;
            out_index   <= '0;
            state_q     <= StTrailer;
          end else begin
            idx_q         <= '0;
            am_move_index <= '0;
            state_q       <= StAddr;
          end
        end

        StAddr: begin
          // Address was presented on entry; ADDR + WAIT + SAMPLE covers the RAM latency.
          if (RAM_LATENCY > 1) begin
            wait_q  <= RamWaitInit;
            state_q <= StWait;
          end else begin
            state_q <= StSample;
          end
        end

        StWait: begin
          if (wait_q <= 4'd1) begin
            state_q <= StSample;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        StSample: begin
          out_uci     <= uci_in;
          out_eval    <= eval_in;
          out_capture <= capture_in;
          out_check   <= {white_in_check_in, black_in_check_in};
          out_index   <= idx_q;
          if (cap_only_q && !capture_in) begin
            if (more_moves) begin
              idx_q         <= idx_inc[MAX_POSITIONS_LOG2-1:0];
              am_move_index <= idx_inc[MAX_POSITIONS_LOG2-1:0];
              state_q       <= StAddr;
            end else begin
              out_valid   <= 1'b1;
              out_trailer <= 1'b1;
              out_uci     <= '0;
              out_eval    <= '0;
              out_capture <= 1'b0;
              out_check   <= '0;
              out_index   <= '0;
              state_q     <= StTrailer;
            end
          end else begin
            out_valid <= 1'b1;
            state_q   <= StEmit;
          end
        end

        StEmit: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_emitted <= out_emitted + WideOne;
            if (more_moves) begin
              idx_q         <= idx_inc[MAX_POSITIONS_LOG2-1:0];
              am_move_index <= idx_inc[MAX_POSITIONS_LOG2-1:0];
              state_q       <= StAddr;
            end else begin
              out_valid   <= 1'b1;
              out_trailer <= 1'b1;
              out_uci     <= '0;
              out_eval    <= '0;
              out_capture <= 1'b0;
              out_check   <= '0;
              out_index   <= '0;
              state_q     <= StTrailer;
            end
          end
        end

        StTrailer: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            out_trailer    <= 1'b0;
            am_clear_moves <= 1'b1;
            state_q        <= StClear;
          end
        end

        StClear: begin
          // The default above drops am_clear_moves, so the pulse spans this state only.
          wait_q  <= ClearWaitInit;
          state_q <= StClearWait;
        end

        StClearWait: begin
          if (wait_q <= 4'd1) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/move_list_streamer.md
MOVE_LIST_STREAMER -- requirements
Module: move_list_streamer

Interface
REQ-001 Parameter MAX_POSITIONS_LOG2, default 8: width of move index and move count.
REQ-002 Parameter EVAL_WIDTH, default 24: width of signed evaluation field.
REQ-003 Parameter UCI_WIDTH, default 16: UCI move field width ({promotion[3:0], to_row, to_col, from_row, from_col}).
REQ-004 Parameter RAM_LATENCY, default 2, range 1..15: cycles from am_move_index change to valid move-RAM outputs.
REQ-005 Parameter CLEAR_WAIT, default 1, range 1..15: cycles held in clear-wait after am_clear_moves pulse.
REQ-006 clk  in  1  single clock; all logic on posedge clk.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  when low in IDLE, am_moves_ready is ignored.
REQ-009 capture_only  in  1  filter mode, sampled at list start: emit capture moves only.
REQ-010 am_moves_ready, am_move_count[MAX_POSITIONS_LOG2], initial_mate, initial_stalemate, initial_thrice_rep  in  move-generator status.
REQ-011 uci_in[UCI_WIDTH], eval_in[EVAL_WIDTH] signed, capture_in, white_in_check_in, black_in_check_in  in  move-RAM read data.
REQ-012 am_move_index  out  MAX_POSITIONS_LOG2  move-RAM read address.
REQ-013 am_clear_moves  out  1  one-cycle pulse releasing the move generator.
REQ-014 out_valid  out  1; out_ready  in  1: record handshake, transfer when both high.
REQ-015 out_uci, out_eval, out_capture, out_check[1:0] ({white,black}), out_index  out  record payload.
REQ-016 out_trailer  out  1  marks end-of-list record; out_status[2:0] ({thrice_rep, stalemate, mate}); out_emitted[MAX_POSITIONS_LOG2+1]  records emitted before trailer.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, START, ADDR, WAIT, SAMPLE, EMIT, TRAILER, CLEAR, CLEAR_WAIT.
REQ-019 IDLE: am_move_index=0; on enable & am_moves_ready latch count, status, capture_only, clear emitted counter -> START.
REQ-020 START: count==0 -> TRAILER; else -> ADDR.
REQ-021 ADDR: drive am_move_index, load wait counter RAM_LATENCY-1 -> WAIT; WAIT decrements, -> SAMPLE at zero (WAIT skipped when RAM_LATENCY==1).
REQ-022 SAMPLE: latch RAM data into the payload registers; if filter rejects (capture_only & !capture_in) go to next index, else -> EMIT.
REQ-023 EMIT: out_valid high, payload stable until out_ready; on transfer increment out_emitted, then next index.
REQ-024 Next index: if index+1 < count -> ADDR with index+1, else -> TRAILER; compare at MAX_POSITIONS_LOG2+1 bits, no wrap.
REQ-025 TRAILER: out_valid=1, out_trailer=1, out_status and out_emitted valid, out_uci/out_eval=0; on transfer -> CLEAR.
REQ-026 CLEAR: am_clear_moves=1 for exactly one cycle -> CLEAR_WAIT for CLEAR_WAIT cycles -> IDLE; am_moves_ready ignored until IDLE.
REQ-027 out_valid never deasserts without a transfer; payload changes only after transfer.
REQ-028 Minimum throughput with out_ready held high: one record per RAM_LATENCY+2 cycles.
REQ-029 Changes on enable/capture_only mid-list have no effect on the current list.

Reset
REQ-030 reset forces IDLE in one cycle from any state, including mid-EMIT; outputs reset to 0: out_valid, out_trailer, am_clear_moves, busy, am_move_index, out_emitted, all payload fields.
REQ-031 No am_clear_moves pulse is generated by reset; list in progress is abandoned.

Verification
REQ-032 count=3, RAM_LATENCY=2, out_ready=1, capture_only=0 -> records index 0,1,2 then trailer out_emitted=3, then a single-cycle am_clear_moves.
REQ-033 count=0, initial_mate=1 -> trailer only, out_status=3'b001, out_emitted=0, then am_clear_moves.
REQ-034 count=4, captures at index 1,3, capture_only=1 -> records index 1,3; trailer out_emitted=2.
REQ-035 out_ready low for 10 cycles during record 0 -> out_valid and payload held constant for all 10 cycles; no records lost or duplicated.
REQ-036 reset asserted during EMIT of index 2 -> next cycle busy=0, out_valid=0, am_move_index=0, am_clear_moves never pulses.
REQ-037 count=2^MAX_POSITIONS_LOG2-1 (255) -> 255 records, last index 255-1=254, trailer out_emitted=255, no index wrap.
